// File: rtl/mips_fwd_pkg.sv
// Shared definitions for the forwarding / load-use hazard controller.
//   FWD_RF / FWD_WB / FWD_MEM : EX operand mux select codes
//   REG_ZERO                  : hard-wired zero register, never forwarded
//   slot_t                    : contents of one pipeline tracking slot
//   fwd_select()              : operand select for one EX source register
package mips_fwd_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // rs/rt/uses_* are only meaningful in the EX slot; MEM and WB carry them along.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             regwrite;
    logic             memread;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             uses_rs;
    logic             uses_rt;
  } slot_t;

  // MEM is checked before WB so the youngest producer wins.
  function automatic logic [1:0] fwd_select(
    input logic             use_src,
    input logic [REG_W-1:0] src,
    input logic             mem_wr,
    input logic [REG_W-1:0] mem_dest,
    input logic             wb_wr,
    input logic [REG_W-1:0] wb_dest
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_src && (src != REG_ZERO)) begin
      if (mem_wr && (mem_dest == src)) begin
        sel = FWD_MEM;
      end else if (wb_wr && (wb_dest == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_ctrl_if.sv
// Bus between the ID/EX pipeline and the forwarding controller.
//   master : pipeline side, drives the ID instruction fields and flush,
//            receives operand selects, stall and the stall counter
//   slave  : controller side
interface fwd_ctrl_if #(
  parameter int REGW = 5,
  parameter int CNTW = 32
);
  logic            id_valid;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            id_uses_rs;
  logic            id_uses_rt;
  logic [REGW-1:0] id_dest;
  logic            id_regwrite;
  logic            id_memread;
  logic            flush;
  logic [1:0]      fwd_a_sel;
  logic [1:0]      fwd_b_sel;
  logic            stall;
  logic [CNTW-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dest, id_regwrite, id_memread, flush,
    input  fwd_a_sel, fwd_b_sel, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dest, id_regwrite, id_memread, flush,
    output fwd_a_sel, fwd_b_sel, stall, stall_count
  );
endinterface

// File: rtl/fwd_stage_slot.sv
// One registered pipeline tracking slot.
//   clk, reset : clock and synchronous active-high reset (clears the slot)
//   bubble_i   : load an empty slot instead of slot_i this cycle
//   slot_i     : contents shifted in from the previous stage
//   slot_o     : current slot contents
module fwd_stage_slot
  import mips_fwd_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  bubble_i,
  input  slot_t slot_i,
  output slot_t slot_o
);

  slot_t slot_q;
  slot_t slot_d;

  always_comb begin
    slot_d = slot_i;
    if (bubble_i) begin
      slot_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller for the pipelined MIPS core.
//   clk, reset : pipeline clock, synchronous active-high reset
//   bus        : slave side of fwd_ctrl_if
//                in : ID instruction fields, flush
//                out: fwd_a_sel / fwd_b_sel (EX operand mux selects),
//                     stall (hold PC and IF/ID, bubble into EX),
//                     stall_count (saturating count of stall cycles)
module fwd_ctrl
  import mips_fwd_pkg::*;
#(
  parameter int REGW = REG_W,
  parameter int CNTW = 32
) (
  input logic       clk,
  input logic       reset,
  fwd_ctrl_if.slave bus
);

  slot_t id_slot;
  slot_t ex_q;
  slot_t mem_q;
  slot_t wb_q;

  logic            load_use;
  logic            stall_int;
  logic [REGW-1:0] ex_dest_w;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;

  always_comb begin
    id_slot          = '0;
    id_slot.valid    = bus.id_valid;
    id_slot.dest     = bus.id_dest;
    id_slot.regwrite = bus.id_regwrite;
    id_slot.memread  = bus.id_memread;
    id_slot.rs       = bus.id_rs;
    id_slot.rt       = bus.id_rt;
    id_slot.uses_rs  = bus.id_uses_rs;
    id_slot.uses_rt  = bus.id_uses_rt;
  end

  // A stalled or squashed ID instruction must not enter EX; a taken branch
  // also kills the instruction currently in EX before it reaches MEM.
  fwd_stage_slot u_ex_slot (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (stall_int | bus.flush),
    .slot_i   (id_slot),
    .slot_o   (ex_q)
  );

  fwd_stage_slot u_mem_slot (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (bus.flush),
    .slot_i   (ex_q),
    .slot_o   (mem_q)
  );

  fwd_stage_slot u_wb_slot (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (1'b0),
    .slot_i   (mem_q),
    .slot_o   (wb_q)
  );

  // Load in EX whose result an ID instruction needs. The one-cycle bubble
  // moves the load to WB by the time the consumer reaches EX, so a load is
  // never forwarded out of MEM.
  assign ex_dest_w = REGW'(ex_q.dest);
  assign load_use  = bus.id_valid && ex_q.valid && ex_q.regwrite && ex_q.memread &&
                     (ex_q.dest != REG_ZERO) &&
                     ((bus.id_uses_rs && (bus.id_rs == ex_dest_w)) ||
                      (bus.id_uses_rt && (bus.id_rt == ex_dest_w)));

  // A flush squashes the dependent instruction anyway, so it wins over stall.
  assign stall_int = load_use && !bus.flush;

  always_comb begin
    cnt_d = cnt_q;
    if (stall_int && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.fwd_a_sel = fwd_select(ex_q.valid && ex_q.uses_rs, ex_q.rs,
                                    mem_q.valid && mem_q.regwrite, mem_q.dest,
                                    wb_q.valid && wb_q.regwrite, wb_q.dest);
  assign bus.fwd_b_sel = fwd_select(ex_q.valid && ex_q.uses_rt, ex_q.rt,
                                    mem_q.valid && mem_q.regwrite, mem_q.dest,
                                    wb_q.valid && wb_q.regwrite, wb_q.dest);
  assign bus.stall       = stall_int;
  assign bus.stall_count = cnt_q;

  // Source-side fields travel with the instruction but are not consulted
  // once it has left EX.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{mem_q.memread, mem_q.rs, mem_q.rt, mem_q.uses_rs, mem_q.uses_rt,
                              wb_q.memread, wb_q.rs, wb_q.rt, wb_q.uses_rs, wb_q.uses_rt};

endmodule
